jt6295_adpcm_enc: RTL and testbench



---
 rtl/jt6295_adpcm_enc.sv | 210 +++++++++++++++++++++
 tb/tb_jt6295_adpcm_enc.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_adpcm_enc.sv
// rtl/jt6295_adpcm_enc.sv - serial 4-bit OKI ADPCM encoder, one bit decided per clock
module jt6295_adpcm_enc #(
    parameter int DW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cen,
    input  logic          i_clr,
    input  logic [DW-1:0] i_din,
    output logic [3:0]    o_dout,
    output logic          o_dout_valid,
    output logic          o_busy,
    output logic          o_overrun
);

    localparam int SW = DW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_B2,
        S_B1,
        S_B0,
        S_UPD
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [DW-1:0]   r_din;
    logic [DW-1:0]   r_pred;
    logic [5:0]      r_idx;
    logic [10:0]     r_step;
    logic [SW-1:0]   r_mag;
    logic            r_sign;
    logic            r_b2;
    logic            r_b1;
    logic            r_b0;
    logic [3:0]      r_dout;
    logic            r_dout_valid;
    logic            r_overrun;

    logic [SW-1:0]   w_pred_ext;
    logic [SW-1:0]   w_diff;
    logic [SW-1:0]   w_abs;
    logic [SW-1:0]   w_step_w;
    logic [SW-1:0]   w_half;
    logic [SW-1:0]   w_quarter;
    logic [SW-1:0]   w_eighth;
    logic [SW-1:0]   w_delta;
    logic [SW-1:0]   w_sum;
    logic [DW-1:0]   w_pred_sat;
    logic signed [7:0] w_adj;
    logic signed [7:0] w_idx_sum;
    logic [5:0]      w_idx_next;

    // OKI step-size table, indexed by the adaptive step index
    function automatic logic [10:0] step_lut(input logic [5:0] idx);
        case (idx)
            6'd0:  step_lut = 11'd16;    6'd1:  step_lut = 11'd17;
            6'd2:  step_lut = 11'd19;    6'd3:  step_lut = 11'd21;
            6'd4:  step_lut = 11'd23;    6'd5:  step_lut = 11'd25;
            6'd6:  step_lut = 11'd28;    6'd7:  step_lut = 11'd31;
            6'd8:  step_lut = 11'd34;    6'd9:  step_lut = 11'd37;
            6'd10: step_lut = 11'd41;    6'd11: step_lut = 11'd45;
            6'd12: step_lut = 11'd50;    6'd13: step_lut = 11'd55;
            6'd14: step_lut = 11'd60;    6'd15: step_lut = 11'd66;
            6'd16: step_lut = 11'd73;    6'd17: step_lut = 11'd80;
            6'd18: step_lut = 11'd88;    6'd19: step_lut = 11'd97;
            6'd20: step_lut = 11'd107;   6'd21: step_lut = 11'd118;
            6'd22: step_lut = 11'd130;   6'd23: step_lut = 11'd143;
            6'd24: step_lut = 11'd157;   6'd25: step_lut = 11'd173;
            6'd26: step_lut = 11'd190;   6'd27: step_lut = 11'd209;
            6'd28: step_lut = 11'd230;   6'd29: step_lut = 11'd253;
            6'd30: step_lut = 11'd279;   6'd31: step_lut = 11'd307;
            6'd32: step_lut = 11'd337;   6'd33: step_lut = 11'd371;
            6'd34: step_lut = 11'd408;   6'd35: step_lut = 11'd449;
            6'd36: step_lut = 11'd494;   6'd37: step_lut = 11'd544;
            6'd38: step_lut = 11'd598;   6'd39: step_lut = 11'd658;
            6'd40: step_lut = 11'd724;   6'd41: step_lut = 11'd796;
            6'd42: step_lut = 11'd876;   6'd43: step_lut = 11'd963;
            6'd44: step_lut = 11'd1060;  6'd45: step_lut = 11'd1166;
            6'd46: step_lut = 11'd1282;  6'd47: step_lut = 11'd1411;
            default: step_lut = 11'd1552;
        endcase
    endfunction

    // Residual, step fractions, decoder-formula reconstruction and index adaptation
    always_comb begin
        w_pred_ext = {r_pred[DW-1], r_pred};
        w_diff     = {r_din[DW-1], r_din} - w_pred_ext;
        w_abs      = w_diff[SW-1] ? (SW'(0) - w_diff) : w_diff;
        w_step_w   = SW'(r_step);
        w_half     = SW'(r_step >> 1);
        w_quarter  = SW'(r_step >> 2);
        w_eighth   = SW'(r_step >> 3);
        w_delta    = w_eighth
                   + (r_b2 ? w_step_w  : SW'(0))
                   + (r_b1 ? w_half    : SW'(0))
                   + (r_b0 ? w_quarter : SW'(0));
        w_sum      = r_sign ? (w_pred_ext - w_delta) : (w_pred_ext + w_delta);
        // A 13-bit result whose top two bits differ lies outside the 12-bit range
        if (w_sum[SW-1] != w_sum[SW-2]) begin
            w_pred_sat = w_sum[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            w_pred_sat = w_sum[DW-1:0];
        end
        if (!r_b2) begin
            w_adj = -8'sd1;
        end else begin
            w_adj = $signed({5'b00000, r_b1, r_b0, 1'b0}) + 8'sd2;
        end
        w_idx_sum = $signed({2'b00, r_idx}) + w_adj;
        if (w_idx_sum < 8'sd0) begin
            w_idx_next = 6'd0;
        end else if (w_idx_sum > 8'sd48) begin
            w_idx_next = 6'd48;
        end else begin
            w_idx_next = w_idx_sum[5:0];
        end
    end

    // Next-state: one bit decision per clock, clr returns to IDLE from anywhere
    always_comb begin
        w_next = r_state;
        if (i_clr) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_cen) w_next = S_DIFF;
                S_DIFF:  w_next = S_B2;
                S_B2:    w_next = S_B1;
                S_B1:    w_next = S_B0;
                S_B0:    w_next = S_UPD;
                S_UPD:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: sample latch, successive approximation, predictor/index update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_din        <= '0;
            r_pred       <= '0;
            r_idx        <= '0;
            r_step       <= '0;
            r_mag        <= '0;
            r_sign       <= 1'b0;
            r_b2         <= 1'b0;
            r_b1         <= 1'b0;
            r_b0         <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_overrun    <= i_cen && (r_state != S_IDLE);
            if (i_clr) begin
                r_pred <= '0;
                r_idx  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_cen) r_din <= i_din;
                    end
                    S_DIFF: begin
                        r_sign <= w_diff[SW-1];
                        r_mag  <= w_abs;
                        r_step <= step_lut(r_idx);
                    end
                    S_B2: begin
                        r_b2 <= (r_mag >= w_step_w);
                        if (r_mag >= w_step_w) r_mag <= r_mag - w_step_w;
                    end
                    S_B1: begin
                        r_b1 <= (r_mag >= w_half);
                        if (r_mag >= w_half) r_mag <= r_mag - w_half;
                    end
                    S_B0: begin
                        r_b0 <= (r_mag >= w_quarter);
                    end
                    S_UPD: begin
                        r_pred       <= w_pred_sat;
                        r_idx        <= w_idx_next;
                        r_dout       <= {r_sign, r_b2, r_b1, r_b0};
                        r_dout_valid <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_jt6295_adpcm_enc.sv
// tb/tb_jt6295_adpcm_enc.sv - self-checking bench for jt6295_adpcm_enc
module tb_jt6295_adpcm_enc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        clr;
    logic [11:0] din;
    logic [3:0]  dout;
    logic        dout_valid;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    int m_pred, m_idx;
    int d_pred, d_idx;

    int step_tab [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                          107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,
                          494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};

    typedef struct {
        bit rst;
        int din;
        int nib;
        int pred;
        int idx;
    } vec_t;

    vec_t vt [14];

    always #5 clk = ~clk;

    jt6295_adpcm_enc #(.DW(12)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cen        (cen),
        .i_clr        (clr),
        .i_din        (din),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_busy       (busy),
        .o_overrun    (overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dut_pred();
        return int'($signed(dut.r_pred));
    endfunction

    function automatic int dut_idx();
        return int'(dut.r_idx);
    endfunction

    task automatic model_update(inout int p, inout int ix, input int nib);
        int st;
        int d;
        st = step_tab[ix];
        d  = st >> 3;
        if ((nib & 4) != 0) d += st;
        if ((nib & 2) != 0) d += st >> 1;
        if ((nib & 1) != 0) d += st >> 2;
        p = ((nib & 8) != 0) ? p - d : p + d;
        if (p > 2047)  p = 2047;
        if (p < -2048) p = -2048;
        ix += ((nib & 7) < 4) ? -1 : 2 * ((nib & 7) - 3);
        if (ix < 0)  ix = 0;
        if (ix > 48) ix = 48;
    endtask

    task automatic model_enc(input int d, output int nib);
        int diff;
        int mag;
        int st;
        diff = d - m_pred;
        st   = step_tab[m_idx];
        mag  = (diff < 0) ? -diff : diff;
        nib  = (diff < 0) ? 8 : 0;
        if (mag >= st) begin
            nib |= 4;
            mag -= st;
        end
        if (mag >= (st >> 1)) begin
            nib |= 2;
            mag -= st >> 1;
        end
        if (mag >= (st >> 2)) nib |= 1;
        model_update(m_pred, m_idx, nib);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cen   = 1'b0;
        clr   = 1'b0;
        din   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m_pred = 0; m_idx = 0;
        d_pred = 0; d_idx = 0;
    endtask

    // cen for one clock, then wait (bounded) for dout_valid; lat counts clocks from cen
    task automatic send(input int d, output int nib, output int lat);
        din = 12'(d);
        cen = 1'b1;
        tick();
        cen = 1'b0;
        lat = 1;
        while (!dout_valid && lat < 12) begin
            tick();
            lat++;
        end
        nib = int'(dout);
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (dout_valid) cnt++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nib, lat, exp, cnt, hold, stay_bad, min_p;
        bit reached;

        vt[0]  = '{1'b1,     0,  0,     2,  0};
        vt[1]  = '{1'b0,     0,  8,     0,  0};
        vt[2]  = '{1'b1,  2047,  7,    30,  8};
        vt[3]  = '{1'b0,  2047,  7,    93, 16};
        vt[4]  = '{1'b0,  2047,  7,   229, 24};
        vt[5]  = '{1'b0,  2047,  7,   522, 32};
        vt[6]  = '{1'b0,  2047,  7,  1153, 40};
        vt[7]  = '{1'b0,  2047,  4,  1967, 42};
        vt[8]  = '{1'b0,  2047,  0,  2047, 41};
        vt[9]  = '{1'b1, -2048, 15,   -30,  8};
        vt[10] = '{1'b0, -2048, 15,   -93, 16};
        vt[11] = '{1'b1,    10,  2,    10,  0};
        vt[12] = '{1'b0,    10,  0,    12,  0};
        vt[13] = '{1'b0,     5,  9,     6,  0};

        // reset values
        rst_n = 1'b0; cen = 1'b0; clr = 1'b0; din = '0;
        tick();
        check("rst_dout",    int'(dout), 0);
        check("rst_valid",   int'(dout_valid), 0);
        check("rst_busy",    int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_pred",    dut_pred(), 0);
        check("rst_idx",     dut_idx(), 0);
        do_reset();

        // directed vectors
        for (int i = 0; i < 14; i++) begin
            if (vt[i].rst) do_reset();
            send(vt[i].din, nib, lat);
            check($sformatf("vec%0d_nib", i),  nib, vt[i].nib);
            check($sformatf("vec%0d_pred", i), dut_pred(), vt[i].pred);
            check($sformatf("vec%0d_idx", i),  dut_idx(), vt[i].idx);
            check($sformatf("vec%0d_lat", i),  lat, 6);
        end

        // busy window and dout hold
        do_reset();
        model_enc(2047, exp);
        din = 12'd2047; cen = 1'b1; tick(); cen = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("busy_n%0d", k),  int'(busy), 1);
            check($sformatf("valid_n%0d", k), int'(dout_valid), 0);
            tick();
        end
        check("busy_n6",  int'(busy), 0);
        check("valid_n6", int'(dout_valid), 1);
        check("dout_n6",  int'(dout), exp);
        hold = int'(dout);
        tick();
        tick();
        check("hold_valid", int'(dout_valid), 0);
        check("hold_dout",  int'(dout), hold);

        // overrun: cen at 0 and 3, then accepted cen at 6
        do_reset();
        model_enc(100, exp);
        din = 12'd100; cen = 1'b1; tick(); cen = 1'b0;
        cnt = int'(dout_valid);
        tick();
        cnt += int'(dout_valid);
        tick();
        cnt += int'(dout_valid);
        din = 12'd555; cen = 1'b1; tick(); cen = 1'b0;
        cnt += int'(dout_valid);
        check("ovr_pulse_c4", int'(overrun), 1);
        check("ovr_busy_c4",  int'(busy), 1);
        tick();
        cnt += int'(dout_valid);
        check("ovr_clear_c5", int'(overrun), 0);
        check("ovr_valid_c1_5", cnt, 0);
        tick();
        check("ovr_valid_c6", int'(dout_valid), 1);
        check("ovr_dout_c6",  int'(dout), exp);
        check("ovr_pred_c6",  dut_pred(), m_pred);
        model_enc(200, exp);
        din = 12'd200; cen = 1'b1; tick(); cen = 1'b0;
        check("ovr_accept_busy", int'(busy), 1);
        check("ovr_accept_ovr",  int'(overrun), 0);
        lat = 1;
        while (!dout_valid && lat < 12) begin
            tick();
            lat++;
        end
        check("ovr_next_lat",  lat, 6);
        check("ovr_next_dout", int'(dout), exp);

        // clr during B1
        do_reset();
        send(500, nib, lat);
        din = 12'd800; cen = 1'b1; tick(); cen = 1'b0;
        tick();
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_b1_busy", int'(busy), 0);
        check("clr_b1_pred", dut_pred(), 0);
        check("clr_b1_idx",  dut_idx(), 0);
        count_valid(8, cnt);
        check("clr_b1_novalid", cnt, 0);

        // clr beats cen in IDLE
        send(-700, nib, lat);
        din = 12'd1000; cen = 1'b1; clr = 1'b1; tick(); cen = 1'b0; clr = 1'b0;
        check("clr_idle_busy", int'(busy), 0);
        check("clr_idle_pred", dut_pred(), 0);
        check("clr_idle_idx",  dut_idx(), 0);
        count_valid(7, cnt);
        check("clr_idle_novalid", cnt, 0);

        // asynchronous reset during UPD
        do_reset();
        send(2047, nib, lat);
        din = 12'd2047; cen = 1'b1; tick(); cen = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rstupd_dout",  int'(dout), 0);
        check("rstupd_valid", int'(dout_valid), 0);
        check("rstupd_busy",  int'(busy), 0);
        check("rstupd_pred",  dut_pred(), 0);
        check("rstupd_idx",   dut_idx(), 0);
        tick();
        rst_n = 1'b1;
        count_valid(8, cnt);
        check("rstupd_novalid", cnt, 0);

        // positive saturation
        do_reset();
        reached = 1'b0; stay_bad = 0;
        for (int i = 0; i < 40; i++) begin
            model_enc(2047, exp);
            send(2047, nib, lat);
            check($sformatf("satp%0d_nib", i), nib, exp);
            check($sformatf("satp%0d_idx", i), dut_idx(), m_idx);
            if (reached && dut_pred() != 2047) stay_bad++;
            if (dut_pred() == 2047) reached = 1'b1;
        end
        check("satp_final_pred", dut_pred(), 2047);
        check("satp_stay", stay_bad, 0);

        // negative saturation
        do_reset();
        min_p = 0;
        for (int i = 0; i < 40; i++) begin
            model_enc(-2048, exp);
            send(-2048, nib, lat);
            check($sformatf("satn%0d_nib", i),  nib, exp);
            check($sformatf("satn%0d_pred", i), dut_pred(), m_pred);
            check($sformatf("satn%0d_idx", i),  dut_idx(), m_idx);
            if (dut_pred() < min_p) min_p = dut_pred();
        end
        check("satn_min_pred", min_p, -2048);

        // loopback through a decoder model
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            int s;
            if (i < 5000) s = int'(2000.0 * $sin(2.0 * 3.14159265 * real'(i) / 97.0));
            else          s = int'($urandom_range(0, 4095)) - 2048;
            model_enc(s, exp);
            send(s, nib, lat);
            check($sformatf("loop%0d_nib", i), nib, exp);
            model_update(d_pred, d_idx, nib);
            check($sformatf("loop%0d_pred", i), dut_pred(), d_pred);
            check($sformatf("loop%0d_lat", i), lat, 6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
